riscv_multicycle_control: RTL and testbench

Control sequencer for the multicycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath's strobes and mux selects. It shares one unified memory port between instruction fetch and load/store, and waits on a memory ready handshake. It sits beside the multicycle datapath (IR, old-PC, ALUOut and MDR registers, regfile, ALU, PC) and replaces the single-cycle core's combinational controller.

---
 rtl/riscv_multicycle_control.sv | 128 ++++++++++++
 tb/tb_riscv_multicycle_control.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_control.sv
// riscv_multicycle_control: FSM sequencer stepping RV32I instructions through fetch/decode/execute/mem/writeback over one shared memory port
module riscv_multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        aluout_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        retired
);
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;
  state_t r_state, w_next;
  logic [6:0] w_opc;
  logic w_r, w_ialu, w_load, w_store, w_branch, w_jal, w_jalr, w_lui, w_auipc, w_legal;
  logic w_mem_req, w_mem_write, w_addr_sel, w_ir_write, w_mdr_write, w_aluout_write, w_pc_write;
  logic w_reg_write, w_retired;
  logic [1:0] w_pc_src, w_alu_a_sel, w_alu_b_sel, w_alu_op, w_wb_sel;
  logic w_unused;
  assign w_unused = &{1'b0, instruction[31:15]};
  assign w_opc    = instruction[6:0];
  assign w_r      = w_opc == 7'b0110011;
  assign w_ialu   = w_opc == 7'b0010011;
  assign w_load   = w_opc == 7'b0000011;
  assign w_store  = w_opc == 7'b0100011;
  assign w_branch = w_opc == 7'b1100011;
  assign w_jal    = w_opc == 7'b1101111;
  assign w_jalr   = w_opc == 7'b1100111 && instruction[14:12] == 3'b000;
  assign w_lui    = w_opc == 7'b0110111;
  assign w_auipc  = w_opc == 7'b0010111;
  assign w_legal  = w_r | w_ialu | w_load | w_store | w_branch | w_jal | w_jalr | w_lui | w_auipc;
  always_ff @(posedge clk)
    r_state <= reset ? S_FETCH : w_next;
  always_comb begin
    w_next         = r_state;
    w_mem_req      = 1'b0;
    w_mem_write    = 1'b0;
    w_addr_sel     = 1'b0;
    w_ir_write     = 1'b0;
    w_mdr_write    = 1'b0;
    w_aluout_write = 1'b0;
    w_pc_write     = 1'b0;
    w_pc_src       = 2'd0;
    w_alu_a_sel    = 2'd0;
    w_alu_b_sel    = 2'd0;
    w_alu_op       = 2'd0;
    w_reg_write    = 1'b0;
    w_wb_sel       = 2'd0;
    w_retired      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        w_next     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_a_sel    = 2'd1;
        w_alu_b_sel    = 2'd1;
        w_aluout_write = 1'b1;
        w_next         = w_legal ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        w_alu_a_sel    = w_auipc ? 2'd1 : 2'd0;
        w_alu_b_sel    = (w_ialu | w_lui | w_auipc | w_load | w_store | w_jalr) ? 2'd1 : 2'd0;
        w_alu_op       = (w_r | w_ialu) ? 2'd1 : w_lui ? 2'd2 : 2'd0;
        w_aluout_write = w_r | w_ialu | w_lui | w_auipc | w_load | w_store;
        w_pc_write     = w_jal | w_jalr | (w_branch & branch_taken);
        w_pc_src       = w_jalr ? 2'd2 : (w_branch | w_jal) ? 2'd1 : 2'd0;
        w_retired      = w_branch;
        w_next         = w_branch ? S_FETCH : (w_load | w_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        w_mem_req   = 1'b1;
        w_addr_sel  = 1'b1;
        w_mem_write = w_store;
        w_mdr_write = mem_ready & w_load;
        w_retired   = mem_ready & w_store;
        w_next      = !mem_ready ? S_MEM : w_load ? S_WB : S_FETCH;
      end
      S_WB: begin
        w_reg_write = instruction[11:7] != 5'd0;
        w_wb_sel    = w_load ? 2'd1 : (w_jal | w_jalr) ? 2'd2 : 2'd0;
        w_retired   = 1'b1;
        w_next      = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end
  // Reset is synchronous for the state, but outputs are also squashed while it is held so an in-flight access or write aborts on the reset edge.
  assign mem_req      = w_mem_req & ~reset;
  assign mem_write    = w_mem_write & ~reset;
  assign addr_sel     = w_addr_sel & ~reset;
  assign ir_write     = w_ir_write & ~reset;
  assign mdr_write    = w_mdr_write & ~reset;
  assign aluout_write = w_aluout_write & ~reset;
  assign pc_write     = w_pc_write & ~reset;
  assign pc_src       = reset ? 2'd0 : w_pc_src;
  assign alu_a_sel    = reset ? 2'd0 : w_alu_a_sel;
  assign alu_b_sel    = reset ? 2'd0 : w_alu_b_sel;
  assign alu_op       = reset ? 2'd0 : w_alu_op;
  assign reg_write    = w_reg_write & ~reset;
  assign wb_sel       = reset ? 2'd0 : w_wb_sel;
  assign retired      = w_retired & ~reset;
  assign state        = reset ? 3'd0 : r_state;
  assign illegal      = ~reset && r_state == S_TRAP;
endmodule

// File: tb/tb_riscv_multicycle_control.sv
// tb_riscv_multicycle_control: directed and randomized checks of the multicycle control sequencer against a cycle-trace model
module tb_riscv_multicycle_control;
  logic clk = 1'b0, reset = 1'b1, branch_taken = 1'b0, mem_ready = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic mem_req, mem_write, addr_sel, ir_write, mdr_write, aluout_write, pc_write, reg_write, illegal, retired;
  logic [1:0] pc_src, alu_a_sel, alu_b_sel, alu_op, wb_sel;
  logic [2:0] state;
  int n_vec = 0, n_err = 0;
  typedef struct packed {
    logic mem_req, mem_write, addr_sel, ir_write, mdr_write, aluout_write, pc_write;
    logic [1:0] pc_src, alu_a_sel, alu_b_sel, alu_op;
    logic reg_write;
    logic [1:0] wb_sel;
    logic [2:0] state;
    logic illegal, retired;
  } outs_t;
  typedef struct { logic rdy; outs_t e; } step_t;
  outs_t obs;
  step_t exp_q[$];
  outs_t got_q[$];
  localparam int C_R = 0, C_IALU = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;
  assign obs = {mem_req, mem_write, addr_sel, ir_write, mdr_write, aluout_write, pc_write,
                pc_src, alu_a_sel, alu_b_sel, alu_op, reg_write, wb_sel, state, illegal, retired};
  riscv_multicycle_control dut (
    .clk(clk), .reset(reset), .instruction(instruction), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .addr_sel(addr_sel), .ir_write(ir_write), .mdr_write(mdr_write),
    .aluout_write(aluout_write), .pc_write(pc_write), .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .state(state), .illegal(illegal), .retired(retired)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end
  function automatic int cls(input logic [31:0] i);
    case (i[6:0])
      7'b0110011: return C_R;
      7'b0010011: return C_IALU;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return i[14:12] == 3'b000 ? C_JALR : C_ILL;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction
  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction
  // Builds the expected per-cycle trace of one instruction: fw/mw are wait cycles in fetch/mem, trap_n cycles are observed in TRAP.
  task automatic model(input logic [31:0] ins, input logic tk, input int fw, input int mw, input int trap_n);
    outs_t o;
    int c;
    step_t s;
    c = cls(ins);
    exp_q.delete();
    for (int k = 0; k < fw; k++) begin
      o = '0; o.mem_req = 1; s.rdy = 0; s.e = o; exp_q.push_back(s);
    end
    o = '0; o.mem_req = 1; o.ir_write = 1; o.pc_write = 1; s.rdy = 1; s.e = o; exp_q.push_back(s);
    o = '0; o.state = 1; o.alu_a_sel = 1; o.alu_b_sel = 1; o.aluout_write = 1; s.rdy = rnd(); s.e = o; exp_q.push_back(s);
    if (c == C_ILL) begin
      for (int k = 0; k < trap_n; k++) begin
        o = '0; o.state = 5; o.illegal = 1; s.rdy = rnd(); s.e = o; exp_q.push_back(s);
      end
      return;
    end
    o = '0; o.state = 2;
    case (c)
      C_R:     begin o.alu_op = 1; o.aluout_write = 1; end
      C_IALU:  begin o.alu_b_sel = 1; o.alu_op = 1; o.aluout_write = 1; end
      C_LUI:   begin o.alu_b_sel = 1; o.alu_op = 2; o.aluout_write = 1; end
      C_AUIPC: begin o.alu_a_sel = 1; o.alu_b_sel = 1; o.aluout_write = 1; end
      C_LOAD, C_STORE: begin o.alu_b_sel = 1; o.aluout_write = 1; end
      C_BR:    begin o.pc_write = tk; o.pc_src = 1; o.retired = 1; end
      C_JAL:   begin o.pc_write = 1; o.pc_src = 1; end
      C_JALR:  begin o.alu_b_sel = 1; o.pc_write = 1; o.pc_src = 2; end
      default: ;
    endcase
    s.rdy = rnd(); s.e = o; exp_q.push_back(s);
    if (c == C_BR) return;
    if (c == C_LOAD || c == C_STORE) begin
      for (int k = 0; k < mw; k++) begin
        o = '0; o.state = 3; o.mem_req = 1; o.addr_sel = 1; o.mem_write = (c == C_STORE); s.rdy = 0; s.e = o; exp_q.push_back(s);
      end
      o = '0; o.state = 3; o.mem_req = 1; o.addr_sel = 1; o.mem_write = (c == C_STORE);
      o.mdr_write = (c == C_LOAD); o.retired = (c == C_STORE); s.rdy = 1; s.e = o; exp_q.push_back(s);
      if (c == C_STORE) return;
    end
    o = '0; o.state = 4; o.reg_write = ins[11:7] != 0; o.retired = 1;
    o.wb_sel = c == C_LOAD ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
    s.rdy = rnd(); s.e = o; exp_q.push_back(s);
  endtask
  task automatic cyc(input logic rdy, input logic tk, output outs_t o);
    mem_ready = rdy;
    branch_taken = tk;
    @(negedge clk);
    o = obs;
    @(posedge clk);
    #1;
  endtask
  task automatic play(input logic [31:0] ins, input logic tk);
    outs_t o;
    instruction = ins;
    got_q.delete();
    foreach (exp_q[k]) begin
      cyc(exp_q[k].rdy, tk, o);
      got_q.push_back(o);
    end
  endtask
  task automatic apply_reset();
    outs_t o;
    reset = 1;
    cyc(rnd(), 0, o);
    cyc(rnd(), 0, o);
    reset = 0;
  endtask
  task automatic test_reset();
    outs_t o, e;
    reset = 1;
    cyc(1, 1, o);
    n_vec++;
    if (o !== '0) begin n_err++; $display("FAIL reset_outputs got %h exp %h", o, outs_t'('0)); end
    reset = 0;
    e = '0; e.mem_req = 1;
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reset_first_fetch%0d got %h exp %h", k, o, e); end
    end
  endtask
  task automatic test_addi();
    outs_t o;
    model(32'h00500093, 0, 0, 0, 0);
    play(32'h00500093, 0);
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k].e) begin n_err++; $display("FAIL addi cyc%0d got %h exp %h", k, got_q[k], exp_q[k].e); end
    end
    n_vec++;
    if ({got_q[0].state, got_q[1].state, got_q[2].state, got_q[3].state, got_q[3].reg_write, got_q[3].wb_sel} !== {3'd0, 3'd1, 3'd2, 3'd4, 1'b1, 2'd0})
      begin n_err++; $display("FAIL addi_states got %0d%0d%0d%0d exp 0124", got_q[0].state, got_q[1].state, got_q[2].state, got_q[3].state); end
    cyc(0, 0, o);
    n_vec++;
    if (o.state !== 3'd0 || o.mem_req !== 1'b1) begin n_err++; $display("FAIL addi_next_fetch got state %0d req %b exp 0 1", o.state, o.mem_req); end
    cyc(1, 0, o);
    apply_reset();
  endtask
  task automatic test_load_wait();
    model(32'h0000A103, 0, 0, 2, 0);
    play(32'h0000A103, 0);
    n_vec++;
    if (got_q.size() != 7) begin n_err++; $display("FAIL lw_len got %0d exp 7", got_q.size()); end
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k].e) begin n_err++; $display("FAIL lw cyc%0d got %h exp %h", k, got_q[k], exp_q[k].e); end
    end
    n_vec++;
    if ({got_q[4].mdr_write, got_q[5].mdr_write, got_q[6].wb_sel} !== {1'b0, 1'b1, 2'd1})
      begin n_err++; $display("FAIL lw_mdr got %b%b/%0d exp 01/1", got_q[4].mdr_write, got_q[5].mdr_write, got_q[6].wb_sel); end
  endtask
  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      model(32'h00000463, 1'(t), 0, 0, 0);
      play(32'h00000463, 1'(t));
      foreach (exp_q[k]) begin
        n_vec++;
        if (got_q[k] !== exp_q[k].e) begin n_err++; $display("FAIL beq_t%0d cyc%0d got %h exp %h", t, k, got_q[k], exp_q[k].e); end
      end
      n_vec++;
      if (got_q.size() != 3 || got_q[2].pc_write !== 1'(t) || got_q[2].pc_src !== 2'd1)
        begin n_err++; $display("FAIL beq_exec_t%0d got pcw %b src %0d exp %0d 1", t, got_q[2].pc_write, got_q[2].pc_src, t); end
    end
  endtask
  task automatic test_jal();
    logic [31:0] ins[2];
    ins[0] = 32'h008000EF;
    ins[1] = 32'h0080006F;
    for (int j = 0; j < 2; j++) begin
      model(ins[j], 0, 1, 0, 0);
      play(ins[j], 0);
      foreach (exp_q[k]) begin
        n_vec++;
        if (got_q[k] !== exp_q[k].e) begin n_err++; $display("FAIL jal%0d cyc%0d got %h exp %h", j, k, got_q[k], exp_q[k].e); end
      end
      n_vec++;
      if (got_q[4].wb_sel !== 2'd2 || got_q[4].reg_write !== (j == 0) || got_q[3].pc_src !== 2'd1)
        begin n_err++; $display("FAIL jal%0d_wb got wb %0d rw %b exp 2 %0d", j, got_q[4].wb_sel, got_q[4].reg_write, j == 0); end
    end
  endtask
  task automatic test_illegal();
    outs_t o, e;
    int reqs;
    model(32'hFFFFFFFF, 0, 0, 0, 20);
    play(32'hFFFFFFFF, 0);
    reqs = 0;
    foreach (exp_q[k]) begin
      n_vec++;
      if (got_q[k] !== exp_q[k].e) begin n_err++; $display("FAIL illegal cyc%0d got %h exp %h", k, got_q[k], exp_q[k].e); end
      if (k >= 2) reqs += int'(got_q[k].mem_req);
    end
    n_vec++;
    if (reqs != 0) begin n_err++; $display("FAIL trap_no_req got %0d exp 0", reqs); end
    reset = 1;
    cyc(1, 0, o);
    n_vec++;
    if (o !== '0) begin n_err++; $display("FAIL trap_reset got %h exp %h", o, outs_t'('0)); end
    reset = 0;
    cyc(0, 0, o);
    e = '0; e.mem_req = 1;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL trap_refetch got %h exp %h", o, e); end
  endtask
  task automatic test_reset_mid();
    outs_t o, e;
    instruction = 32'h0000A103;
    cyc(0, 0, o);
    reset = 1;
    cyc(1, 0, o);
    n_vec++;
    if (o !== '0) begin n_err++; $display("FAIL reset_in_fetch got %h exp %h", o, outs_t'('0)); end
    reset = 0;
    cyc(1, 0, o);
    e = '0; e.mem_req = 1; e.ir_write = 1; e.pc_write = 1;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL fetch_after_reset got %h exp %h", o, e); end
    cyc(0, 0, o);
    cyc(0, 0, o);
    cyc(0, 0, o);
    e = '0; e.state = 3; e.mem_req = 1; e.addr_sel = 1;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL mem_wait got %h exp %h", o, e); end
    reset = 1;
    cyc(1, 0, o);
    n_vec++;
    if (o !== '0) begin n_err++; $display("FAIL reset_in_mem got %h exp %h", o, outs_t'('0)); end
    reset = 0;
    cyc(0, 0, o);
    e = '0; e.mem_req = 1;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL fetch_after_mem_reset got %h exp %h", o, e); end
    apply_reset();
  endtask
  task automatic test_random();
    logic [6:0] ops[10];
    logic [31:0] ins;
    logic tk;
    int pick, nret, c;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111011};
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      pick = $urandom_range(0, 9);
      ins[6:0] = ops[pick];
      if (pick == 6 && $urandom_range(0, 3) != 0) ins[14:12] = 3'b000;
      if ($urandom_range(0, 4) == 0) ins[11:7] = 5'd0;
      tk = rnd();
      c = cls(ins);
      model(ins, tk, $urandom_range(0, 3), $urandom_range(0, 3), 3);
      play(ins, tk);
      nret = 0;
      foreach (exp_q[k]) begin
        n_vec++;
        if (got_q[k] !== exp_q[k].e) begin n_err++; $display("FAIL rand%0d ins %h cyc%0d got %h exp %h", n, ins, k, got_q[k], exp_q[k].e); end
        nret += int'(got_q[k].retired);
      end
      n_vec++;
      if (nret != (c == C_ILL ? 0 : 1)) begin n_err++; $display("FAIL rand%0d_retired got %0d exp %0d", n, nret, c == C_ILL ? 0 : 1); end
      if (c == C_ILL) apply_reset();
    end
  endtask
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
